// File: rtl/cajero_multicanal_param.sv
// Parametrised ATM session controller: PIN entry with retry lock,
// deposit/withdrawal on a session balance, card-removal abort and
// inactivity timeout. All outputs are registered.
//
// state            | meaning
// -----------------+---------------------------------------------
// S_IDLE           | no session; waiting for a card
// S_RECIBIENDO_PIN | collecting PIN digits
// S_COMPARAR_PIN   | one cycle: compare entered PIN with stored PIN
// S_ESPERA_MONTO   | PIN accepted; waiting for an amount strobe
// S_TRANSACCION    | one cycle: apply deposit or withdrawal
// S_BLOQUEO        | locked after too many failures; reset only
module cajero_multicanal_param #(
    parameter int PIN_DIGITS     = 4,
    parameter int BAL_W          = 64,
    parameter int MONTO_W        = 32,
    parameter int MAX_INTENTOS   = 3,
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    tipo_trans,
    input  logic                    digito_stb,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin,
    input  logic [BAL_W-1:0]        balance_inicial,
    input  logic [MONTO_W-1:0]      monto,
    input  logic                    monto_stb,
    output logic [BAL_W-1:0]        balance_actualizado,
    output logic                    balance_stb,
    output logic                    entregar_dinero,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic                    fondos_insuficientes,
    output logic                    timeout
);

    localparam int PIN_W = 4 * PIN_DIGITS;
    localparam int DC_W  = $clog2(PIN_DIGITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CICLOS + 1);

    localparam logic [DC_W-1:0] DC_LAST  = DC_W'(PIN_DIGITS - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [2:0]      INT_MAX  = 3'(MAX_INTENTOS);
    localparam logic [2:0]      INT_WARN = 3'(MAX_INTENTOS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECIBIENDO_PIN,
        S_COMPARAR_PIN,
        S_ESPERA_MONTO,
        S_TRANSACCION,
        S_BLOQUEO
    } estado_t;

    estado_t estado, estado_sig;

    logic [PIN_W-1:0]   pin_reg;
    logic [DC_W-1:0]    dcnt;
    logic [TO_W-1:0]    tcnt;
    logic [2:0]         intentos;
    logic [MONTO_W-1:0] monto_reg;
    logic               tipo_reg;

    logic               digito_ok;
    logic               pin_ok;
    logic               to_exp;
    logic [2:0]         int_next;
    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     suma;
    logic               alcanza;

    logic [BAL_W-1:0]   bal_d;
    logic               bal_stb_d, entregar_d, pin_inc_d, adv_d, blq_d, fondos_d, timeout_d;

    assign digito_ok = digito_stb && (digito <= 4'd9);
    assign pin_ok    = (pin_reg == pin);
    assign to_exp    = (tcnt == TO_LAST);
    assign int_next  = intentos + 3'd1;
    assign monto_ext = BAL_W'(monto_reg);
    assign suma      = {1'b0, balance_actualizado} + {1'b0, monto_ext};
    assign alcanza   = (monto_ext <= balance_actualizado);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= S_IDLE;
        else        estado <= estado_sig;
    end

    // Next-state decode; card removal outranks strobes, strobes outrank expiry
    always_comb begin
        estado_sig = estado;
        case (estado)
            S_IDLE: begin
                if (tarjeta_recibida) estado_sig = S_RECIBIENDO_PIN;
            end
            S_RECIBIENDO_PIN: begin
                if (!tarjeta_recibida)                estado_sig = S_IDLE;
                else if (digito_ok && dcnt == DC_LAST) estado_sig = S_COMPARAR_PIN;
                else if (!digito_ok && to_exp)         estado_sig = S_IDLE;
            end
            S_COMPARAR_PIN: begin
                if (!tarjeta_recibida)       estado_sig = S_IDLE;
                else if (pin_ok)             estado_sig = S_ESPERA_MONTO;
                else if (int_next == INT_MAX) estado_sig = S_BLOQUEO;
                else                          estado_sig = S_RECIBIENDO_PIN;
            end
            S_ESPERA_MONTO: begin
                if (!tarjeta_recibida) estado_sig = S_IDLE;
                else if (monto_stb)    estado_sig = S_TRANSACCION;
                else if (to_exp)       estado_sig = S_IDLE;
            end
            S_TRANSACCION: estado_sig = S_IDLE;
            S_BLOQUEO:     estado_sig = S_BLOQUEO;
            default:       estado_sig = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        bal_d      = balance_actualizado;
        bal_stb_d  = 1'b0;
        entregar_d = 1'b0;
        pin_inc_d  = 1'b0;
        adv_d      = advertencia;
        blq_d      = bloqueo;
        fondos_d   = 1'b0;
        timeout_d  = 1'b0;
        case (estado)
            S_IDLE: begin
                if (tarjeta_recibida) bal_d = balance_inicial;
            end
            S_RECIBIENDO_PIN: begin
                if (tarjeta_recibida && !digito_ok && to_exp) timeout_d = 1'b1;
            end
            S_COMPARAR_PIN: begin
                if (tarjeta_recibida) begin
                    if (pin_ok) begin
                        adv_d = 1'b0;
                    end else begin
                        pin_inc_d = 1'b1;
                        if (int_next == INT_MAX) begin
                            adv_d = 1'b0;
                            blq_d = 1'b1;
                        end else if (int_next == INT_WARN) begin
                            adv_d = 1'b1;
                        end
                    end
                end
            end
            S_ESPERA_MONTO: begin
                if (tarjeta_recibida && !monto_stb && to_exp) timeout_d = 1'b1;
            end
            S_TRANSACCION: begin
                if (!tipo_reg) begin
                    bal_d     = suma[BAL_W] ? {BAL_W{1'b1}} : suma[BAL_W-1:0];
                    bal_stb_d = 1'b1;
                end else if (alcanza) begin
                    bal_d      = balance_actualizado - monto_ext;
                    bal_stb_d  = 1'b1;
                    entregar_d = 1'b1;
                end else begin
                    fondos_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            balance_actualizado  <= '0;
            balance_stb          <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
            timeout              <= 1'b0;
        end else begin
            balance_actualizado  <= bal_d;
            balance_stb          <= bal_stb_d;
            entregar_dinero      <= entregar_d;
            pin_incorrecto       <= pin_inc_d;
            advertencia          <= adv_d;
            bloqueo              <= blq_d;
            fondos_insuficientes <= fondos_d;
            timeout              <= timeout_d;
        end
    end

    // Session datapath: PIN shift register, digit/timeout/attempt counters, amount latch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pin_reg   <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
            intentos  <= '0;
            monto_reg <= '0;
            tipo_reg  <= 1'b0;
        end else begin
            case (estado)
                S_IDLE: begin
                    if (tarjeta_recibida) begin
                        dcnt <= '0;
                        tcnt <= '0;
                    end
                end
                S_RECIBIENDO_PIN: begin
                    if (!tarjeta_recibida) begin
                        dcnt <= '0;
                    end else if (digito_ok) begin
                        pin_reg <= (pin_reg << 4) | PIN_W'(digito);
                        dcnt    <= dcnt + 1'b1;
                        tcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_COMPARAR_PIN: begin
                    tcnt <= '0;
                    dcnt <= '0;
                    if (tarjeta_recibida) begin
                        if (pin_ok) intentos <= '0;
                        else        intentos <= int_next;
                    end
                end
                S_ESPERA_MONTO: begin
                    if (!tarjeta_recibida) begin
                        dcnt <= '0;
                    end else if (monto_stb) begin
                        monto_reg <= monto;
                        tipo_reg  <= tipo_trans;
                        tcnt      <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
